// File: rtl/fact_accel_ctrl_pkg.sv
// fact_accel_ctrl_pkg: register map, FSM encoding and status layout for the factorial accelerator
package fact_accel_ctrl_pkg;
   localparam logic [1:0] A_N      = 2'd0;
   localparam logic [1:0] A_GO     = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_RESULT = 2'd3;
   localparam int ST_DONE = 0;
   localparam int ST_ERR  = 1;
   localparam int ST_BUSY = 2;
   localparam int MAX_N   = 12;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MULT,
      S_DONE,
      S_ERR
   } state_t;
endpackage

// File: rtl/fact_accel_ctrl_dp.sv
// fact_dp: down-counter and running product for iterative factorial
module fact_dp #(
   parameter int WIDTH = 32,
   parameter int NW    = 4,
   parameter int MAX_N = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [NW-1:0]    n,
   output logic [WIDTH-1:0] prod,
   output logic             cnt_le1,
   output logic             n_gt_max
);
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   always_comb begin
      cnt_d  = load ? n : step ? cnt_q - NW'(1) : cnt_q;
      prod_d = load ? WIDTH'(1) : step ? prod_q * WIDTH'(cnt_q) : prod_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         prod_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
      end
   end
   assign prod     = prod_q;
   assign cnt_le1  = cnt_q <= NW'(1);
   assign n_gt_max = int'(n) > MAX_N;
endmodule

// File: rtl/fact_accel_ctrl.sv
// fact_accel_ctrl: memory-mapped factorial accelerator with go/poll/read interface
module fact_accel_ctrl
   import fact_accel_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NW    = 4,
   parameter int MAX_N = fact_accel_ctrl_pkg::MAX_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       a,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd
);
   state_t           state_q, state_d;
   logic [NW-1:0]    n_q, n_d;
   logic             go_q, go_d, done_q, done_d, err_q, err_d;
   logic [WIDTH-1:0] result_q, result_d, prod;
   logic             busy, go_ok, load, step, fin, cnt_le1, n_gt_max;
   logic [2:0]       status;
   logic             wd_unused;
   assign wd_unused = ^wd[WIDTH-1:NW];
   fact_dp #(.WIDTH(WIDTH), .NW(NW), .MAX_N(MAX_N)) u_dp (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .n       (n_q),
      .prod    (prod),
      .cnt_le1 (cnt_le1),
      .n_gt_max(n_gt_max)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         go_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         go_q     <= go_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end
   // A go is only honoured when idle or finished; the busy edge that reaches DONE drops it.
   always_comb begin
      busy    = state_q == S_LOAD || state_q == S_MULT;
      go_ok   = we && a == A_GO && wd[0] && !busy;
      state_d = go_ok ? S_LOAD :
                state_q == S_LOAD ? (n_gt_max ? S_ERR : S_MULT) :
                state_q == S_MULT && cnt_le1 ? S_DONE : state_q;
   end
   always_comb begin
      load     = state_q == S_LOAD;
      step     = state_q == S_MULT && !cnt_le1;
      fin      = state_q == S_MULT && cnt_le1;
      n_d      = we && a == A_N ? wd[NW-1:0] : n_q;
      go_d     = we && a == A_GO ? wd[0] : go_q;
      done_d   = load ? 1'b0 : fin ? 1'b1 : done_q;
      err_d    = load ? n_gt_max : err_q;
      result_d = load && n_gt_max ? '0 : fin ? prod : result_q;
      status          = '0;
      status[ST_DONE] = done_q;
      status[ST_ERR]  = err_q;
      status[ST_BUSY] = busy;
      rd = a == A_N      ? WIDTH'(n_q) :
           a == A_GO     ? WIDTH'(go_q) :
           a == A_STATUS ? WIDTH'(status) : result_q;
   end
endmodule

// File: tb/tb_fact_accel_ctrl.sv
// tb_fact_accel_ctrl: directed checks of the factorial accelerator register interface
module tb_fact_accel_ctrl;
   logic        clk = 1'b0;
   logic        rst, we;
   logic [1:0]  a;
   logic [31:0] wd, rd;
   int          n_tests = 0, n_fail = 0;
   fact_accel_ctrl dut (.clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      we = 1'b1;
      a  = addr;
      wd = data;
      @(posedge clk);
      #1 we = 1'b0;
   endtask
   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask
   task automatic rchk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      a = addr;
      #1 check(tag, rd, exp);
   endtask
   initial begin
      rst = 1'b0; we = 1'b0; a = 2'd0; wd = '0;
      tick(2);
      rchk("rst_n", 2'd0, 0); rchk("rst_go", 2'd1, 0);
      rchk("rst_st", 2'd2, 0); rchk("rst_res", 2'd3, 0);
      rst = 1'b1;
      tick(1);
      // n=5
      wr(2'd0, 5); wr(2'd1, 1);
      rchk("n5_e0_st", 2'd2, 3'b100);
      rchk("n5_nreg", 2'd0, 5); rchk("n5_goreg", 2'd1, 1);
      tick(1); rchk("n5_e1_st", 2'd2, 3'b100);
      tick(4); rchk("n5_e5_st", 2'd2, 3'b100);
      tick(1); rchk("n5_e6_st", 2'd2, 3'b001); rchk("n5_res", 2'd3, 120);
      // back-to-back go
      wr(2'd1, 1); rchk("b2b_e0_st", 2'd2, 3'b101);
      tick(1); rchk("b2b_e1_st", 2'd2, 3'b100); rchk("b2b_e1_res", 2'd3, 120);
      tick(4); rchk("b2b_e5_res", 2'd3, 120);
      tick(1); rchk("b2b_e6_st", 2'd2, 3'b001); rchk("b2b_e6_res", 2'd3, 120);
      // n=1
      wr(2'd0, 1); wr(2'd1, 1);
      tick(1); rchk("n1_e1_st", 2'd2, 3'b100); rchk("n1_e1_res", 2'd3, 120);
      tick(1); rchk("n1_e2_st", 2'd2, 3'b001); rchk("n1_res", 2'd3, 1);
      // n=12
      wr(2'd0, 12); wr(2'd1, 1);
      tick(12); rchk("n12_e12_st", 2'd2, 3'b100);
      tick(1); rchk("n12_e13_st", 2'd2, 3'b001); rchk("n12_res", 2'd3, 32'h1C8C_FC00);
      // n=13 and n=15 error
      wr(2'd0, 13); wr(2'd1, 1);
      tick(1); rchk("n13_st", 2'd2, 3'b010); rchk("n13_res", 2'd3, 0);
      wr(2'd0, 15); wr(2'd1, 1);
      tick(1); rchk("n15_st", 2'd2, 3'b010);
      // n=0
      wr(2'd0, 0); wr(2'd1, 1);
      tick(1); rchk("n0_e1_st", 2'd2, 3'b100);
      tick(1); rchk("n0_e2_st", 2'd2, 3'b001); rchk("n0_res", 2'd3, 1);
      // go and N writes while busy do not disturb the run
      wr(2'd0, 6); wr(2'd1, 1);
      tick(2); wr(2'd1, 1); wr(2'd0, 3);
      tick(2); rchk("busy_e6_st", 2'd2, 3'b100);
      tick(1); rchk("busy_e7_st", 2'd2, 3'b001); rchk("busy_res", 2'd3, 720);
      rchk("busy_nreg", 2'd0, 3);
      wr(2'd1, 1);
      tick(4); rchk("n3_st", 2'd2, 3'b001); rchk("n3_res", 2'd3, 6);
      // go on the edge MULT reaches DONE is dropped
      wr(2'd0, 2); wr(2'd1, 1);
      tick(2); wr(2'd1, 1);
      rchk("race_e3_st", 2'd2, 3'b001); rchk("race_res", 2'd3, 2);
      tick(1); rchk("race_e4_st", 2'd2, 3'b001);
      // reset mid-operation
      wr(2'd0, 5); wr(2'd1, 1);
      tick(2);
      rst = 1'b0;
      #2;
      rchk("mrst_n", 2'd0, 0); rchk("mrst_go", 2'd1, 0);
      rchk("mrst_st", 2'd2, 0); rchk("mrst_res", 2'd3, 0);
      tick(1); rst = 1'b1;
      tick(3); rchk("mrst_idle_st", 2'd2, 0); rchk("mrst_idle_res", 2'd3, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
